serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Bit-serial (LSB-first) subtractor computing a - b - bin over
//             WIDTH clock cycles, with registered diff/bout and a done pulse.
//  Revision : 1.0 - initial release
// ============================================================================

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned              c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0]       c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_bit_d;
    logic               w_bit_br;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == c_CNT_LAST);

    // One full-subtractor cell, fed from the LSBs of the operand shifters
    assign w_bit_d  = r_a[0] ^ r_b[0] ^ r_br;
    assign w_bit_br = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (w_run) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_bit_d, r_res[WIDTH-1:1]};
            r_br  <= w_bit_br;
            r_cnt <= r_cnt + 1'b1;
            // Outputs change only on the final step, so they hold the old result during RUN
            if (w_last) begin
                r_diff <= {w_bit_d, r_res[WIDTH-1:1]};
                r_bout <= w_bit_br;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Brief    : Directed self-checking bench for serial_subtractor (WIDTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================

module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is positioned just after an edge; start is presented for one edge.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ed, input logic eb,
                          input bit inject);
        int          n;
        int          busy_cnt;
        logic [7:0]  prev_d;
        logic        prev_b;
        start  = 1'b1;
        a      = ia;
        b      = ib;
        bin    = ibin;
        prev_d = diff;
        prev_b = bout;
        tick();
        start    = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        bin      = 1'($urandom);
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (n == 4) begin
                check({tag, " hold diff"}, 32'(diff), 32'(prev_d));
                check({tag, " hold bout"}, 32'(bout), 32'(prev_b));
            end
            if (inject && n == 3) begin
                start = 1'b1;
                a     = ~ia;
                b     = ia;
                bin   = ~ibin;
            end
            if (inject && n == 4) start = 1'b0;
            tick();
            n++;
        end
        if (busy) busy_cnt++;
        check({tag, " latency"}, 32'(n + 1), 32'(WIDTH + 1));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " bout"}, 32'(bout), 32'(eb));
        start = 1'b0;
        tick();
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle diff"}, 32'(diff), 32'(ed));
    endtask

    task automatic quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        start  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (done) pulses++;
            tick();
        end
        check({tag, " extra done"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        tick();
        tick();
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;

        // Start on the very first edge after reset release
        run_op("100-37",    8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0);
        run_op("5-10",      8'd5,   8'd10,  1'b0, 8'd251, 1'b1, 1'b0);
        run_op("0-0-1",     8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0);
        run_op("255-255",   8'd255, 8'd255, 1'b0, 8'd0,   1'b0, 1'b0);
        run_op("128-127-1", 8'd128, 8'd127, 1'b1, 8'd0,   1'b0, 1'b0);
        run_op("170-85",    8'd170, 8'd85,  1'b0, 8'd85,  1'b0, 1'b0);
        quiet("gap", 2);

        // Second start with different operands during RUN must be ignored
        run_op("50-20-1 inj", 8'd50, 8'd20, 1'b1, 8'd29, 1'b0, 1'b1);
        quiet("inject", 12);

        // Reset on the 4th RUN cycle aborts the operation
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd37;
        bin   = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        rst = 1'b0;
        quiet("abort", 15);

        // Back-to-back: second start lands in the IDLE cycle right after DONE
        run_op("200-1 b2b", 8'd200, 8'd1, 1'b0, 8'd199, 1'b0, 1'b0);
        run_op("1-2 b2b",   8'd1,   8'd2, 1'b0, 8'd255, 1'b1, 1'b0);
        quiet("b2b", 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
